// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wb_pkg
// Brief   : Shared Wishbone bus widths and the burst-master FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package wb_pkg;

  localparam int WB_DW = 32;  // Wishbone data/address width
  localparam int WB_SW = 4;   // Wishbone byte-select width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : wb_burst_master
// Brief   : Pipelined Wishbone B4 initiator moving a block of 32-bit words
//           between a write/read stream and the Wishbone bus.
// Revision: 1.0 - initial release
// ============================================================================
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int LEN_W   = 12,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_DW-1:0] cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WB_SW-1:0] cmd_sel,
  input  logic [WB_DW-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [WB_DW-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [WB_DW-1:0] o_wb_addr,
  output logic [WB_DW-1:0] o_wb_data,
  output logic [WB_SW-1:0] o_wb_sel,
  input  logic             i_wb_stall,
  input  logic             i_wb_ack,
  input  logic             i_wb_err,
  input  logic [WB_DW-1:0] i_wb_data
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   issued_q, issued_d;
  logic [LEN_W-1:0]   acked_q, acked_d;
  logic [3:0]         out_q, out_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [WB_DW-1:0]   next_addr_q, next_addr_d;
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic [WB_DW-1:0]   addr_q, addr_d;
  logic [WB_DW-1:0]   data_q, data_d;
  logic [WB_SW-1:0]   sel_q, sel_d;
  logic [WB_DW-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               wr_ready_c;

  // Bus handshake qualifiers; acks with nothing outstanding are ignored.
  logic w_accept, w_ack_ok, w_load_slot, w_room, w_can_issue, w_abort;
  assign w_accept    = stb_q & ~i_wb_stall;
  assign w_ack_ok    = i_wb_ack & (out_q != 4'd0);
  assign w_load_slot = ~stb_q | ~i_wb_stall;
  // Room counts an accept happening this cycle so a freshly loaded stb can never overflow.
  assign w_room      = ({1'b0, out_q} + {4'b0, w_accept}) < 5'(MAX_OUT);
  assign w_can_issue = (state_q == ST_ISSUE) && (issued_q < len_q) && w_room && (!we_q || wr_valid);
  assign w_abort     = (state_q != ST_IDLE) && (i_wb_err || (tmo_q == TMO_W'(TIMEOUT)));

  // Next-state and bus-output computation; abort overrides everything else.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    len_d       = len_q;
    issued_d    = issued_q;
    acked_d     = acked_q + LEN_W'(w_ack_ok);
    out_d       = out_q + 4'(w_accept) - 4'(w_ack_ok);
    tmo_d       = (w_ack_ok || out_q == 4'd0) ? '0 : tmo_q + TMO_W'(1);
    next_addr_d = next_addr_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    wr_ready_c  = 1'b0;

    if (w_ack_ok && !we_q) begin
      rd_data_d  = i_wb_data;
      rd_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          err_d = 1'b0;
          if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = ST_ISSUE;
            we_d        = cmd_we;
            len_d       = cmd_len;
            sel_d       = cmd_sel;
            next_addr_d = cmd_addr & ~32'h3;
            issued_d    = '0;
            acked_d     = '0;
            out_d       = '0;
            tmo_d       = '0;
          end
        end
      end
      ST_ISSUE: begin
        if (w_load_slot) begin
          if (w_can_issue) begin
            stb_d       = 1'b1;
            cyc_d       = 1'b1;
            addr_d      = next_addr_q;
            data_d      = wr_data;
            wr_ready_c  = we_q;
            next_addr_d = next_addr_q + 32'd4;
            issued_d    = issued_q + LEN_W'(1);
          end else begin
            stb_d = 1'b0;
          end
          // All beats loaded and the last one no longer waiting on the bus.
          if (issued_q == len_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (acked_d == len_q) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_abort) begin
      state_d    = ST_IDLE;
      cyc_d      = 1'b0;
      stb_d      = 1'b0;
      err_d      = 1'b1;
      done_d     = 1'b1;
      wr_ready_c = 1'b0;
      out_d      = '0;
      tmo_d      = '0;
    end
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      len_q       <= '0;
      issued_q    <= '0;
      acked_q     <= '0;
      out_q       <= '0;
      tmo_q       <= '0;
      next_addr_q <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      sel_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      acked_q     <= acked_d;
      out_q       <= out_d;
      tmo_q       <= tmo_d;
      next_addr_q <= next_addr_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // cmd_ready is gated by reset so every output reads 0 while reset is held.
  assign cmd_ready = (state_q == ST_IDLE) && !reset;
  assign busy      = (state_q != ST_IDLE);
  assign wr_ready  = wr_ready_c;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;
  assign o_wb_sel  = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_burst_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_burst_master
// Brief   : Self-checking bench for wb_burst_master with a pipelined slave
//           model and accept/read-data scoreboards.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_burst_master;

  localparam int LEN_W   = 12;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 1023;
  localparam logic [31:0] WR_BASE = 32'hA500_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
    logic        we;
  } beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_we = 1'b0;
  logic [31:0]      cmd_addr = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [3:0]       cmd_sel = '0;
  logic [31:0]      wr_data;
  logic             wr_valid = 1'b1;
  logic             wr_ready;
  logic [31:0]      rd_data;
  logic             rd_valid, busy, done, err;
  logic             o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0]      o_wb_addr, o_wb_data;
  logic [3:0]       o_wb_sel;
  logic             i_wb_stall = 1'b0;
  logic             i_wb_ack = 1'b0;
  logic             i_wb_err = 1'b0;
  logic [31:0]      i_wb_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // slave / monitor state
  logic [31:0] mem [64];
  beat_t       exp_acc[$];
  logic [31:0] exp_rd[$];
  beat_t       pend[$];
  int          stall_left = 0, ack_hold = 0;
  bit          err_mode = 0, never_ack = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  int          acc_cnt = 0, wr_ready_cnt = 0, rd_valid_cnt = 0, done_cnt = 0;
  int          max_pend = 0, stb_viol = 0;
  int          wr_cnt = 0;
  bit          wr_inc = 0;

  assign wr_data = WR_BASE + 32'(wr_cnt);

  wb_burst_master #(.LEN_W(LEN_W), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .err(err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
    .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
    .i_wb_data(i_wb_data)
  );

  always #5 clk = ~clk;

  // Advance the write stream after every consumed word.
  always @(posedge clk) begin
    #1;
    if (wr_inc) begin
      wr_cnt = wr_cnt + 1;
      wr_inc = 0;
    end
  end

  // Slave model and output monitor, evaluated mid-cycle while DUT outputs are stable.
  always @(negedge clk) begin
    if (reset) begin
      i_wb_stall = 0; i_wb_ack = 0; i_wb_err = 0;
      pend.delete();
      prev_stall = 0;
    end else begin
      if (wr_ready) begin wr_ready_cnt++; wr_inc = 1; end
      if (done) begin
        done_cnt++;
        n_cmp++;
        if (o_wb_cyc !== 1'b0) begin
          n_bad++; $display("FAIL cyc_with_done: cyc=%b required 0", o_wb_cyc);
        end
      end
      if (rd_valid) begin
        rd_valid_cnt++;
        n_cmp++;
        if (exp_rd.size() == 0) begin
          n_bad++; $display("FAIL rd_extra: rd_data=%h with nothing expected", rd_data);
        end else begin
          logic [31:0] e;
          e = exp_rd.pop_front();
          if (rd_data !== e) begin
            n_bad++; $display("FAIL rd_data: got %h required %h", rd_data, e);
          end
        end
      end
      if (prev_stall) begin
        n_cmp++;
        if (o_wb_stb !== 1'b1 || o_wb_addr !== prev_addr) begin
          n_bad++; $display("FAIL stall_hold: stb=%b addr=%h required stb=1 addr=%h", o_wb_stb, o_wb_addr, prev_addr);
        end
      end
      if (pend.size() >= MAX_OUT && o_wb_stb) stb_viol++;
      if (pend.size() > max_pend) max_pend = pend.size();

      // response for the oldest outstanding request
      i_wb_ack = 0; i_wb_err = 0;
      if (!o_wb_cyc) begin
        pend.delete();
      end else if (pend.size() > 0 && !never_ack) begin
        if (ack_hold > 0) ack_hold--;
        else if (err_mode) begin
          i_wb_err = 1; err_mode = 0;
        end else begin
          beat_t r;
          r = pend.pop_front();
          i_wb_ack  = 1;
          i_wb_data = r.we ? 32'h0 : mem[r.addr[7:2]];
        end
      end

      // stall or accept the current request
      i_wb_stall = 0;
      if (o_wb_cyc && o_wb_stb) begin
        if (stall_left > 0) begin
          stall_left--; i_wb_stall = 1;
        end else begin
          acc_cnt++;
          n_cmp++;
          if (exp_acc.size() == 0) begin
            n_bad++; $display("FAIL acc_extra: addr=%h with nothing expected", o_wb_addr);
          end else begin
            beat_t b;
            b = exp_acc.pop_front();
            if (o_wb_addr !== b.addr || o_wb_sel !== b.sel || o_wb_we !== b.we || (b.we && o_wb_data !== b.data)) begin
              n_bad++;
              $display("FAIL acc_beat: got addr=%h data=%h sel=%h we=%b required addr=%h data=%h sel=%h we=%b",
                       o_wb_addr, o_wb_data, o_wb_sel, o_wb_we, b.addr, b.data, b.sel, b.we);
            end
          end
          if (o_wb_we) mem[o_wb_addr[7:2]] = o_wb_data;
          pend.push_back('{addr: o_wb_addr, data: o_wb_data, sel: o_wb_sel, we: o_wb_we});
        end
      end
      prev_stall = i_wb_stall;
      prev_addr  = o_wb_addr;
    end
  end

  task automatic clear_stats();
    acc_cnt = 0; wr_ready_cnt = 0; rd_valid_cnt = 0; done_cnt = 0;
    max_pend = 0; stb_viol = 0;
  endtask

  task automatic flush();
    exp_acc.delete(); exp_rd.delete();
  endtask

  // Present one command and record the beats/read data it must produce.
  task automatic issue_cmd(input logic we, input logic [31:0] addr, input int len, input logic [3:0] sel);
    @(negedge clk);
    #1;
    cmd_we = we; cmd_addr = addr; cmd_len = LEN_W'(len); cmd_sel = sel; cmd_valid = 1;
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.addr = (addr & ~32'h3) + 32'(4 * i);
      b.data = WR_BASE + 32'(wr_cnt + i);
      b.sel  = sel;
      b.we   = we;
      exp_acc.push_back(b);
      if (!we) exp_rd.push_back(mem[b.addr[7:2]]);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL cmd_ready: got %b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done(input int budget, input string tag, output int cycles);
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (done === 1'b1) return;
    end
    n_cmp++; n_bad++;
    $display("FAIL %s: done=%b after %0d cycles required 1", tag, done, budget);
  endtask

  task automatic test_reset();
    reset = 1;
    #1;
    n_cmp++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, wr_ready, rd_data,
         rd_valid, busy, done, err, cmd_ready} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: cyc=%b stb=%b addr=%h busy=%b cmd_ready=%b required all 0",
                        o_wb_cyc, o_wb_stb, o_wb_addr, busy, cmd_ready);
    end
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
  endtask

  task automatic test_write_burst();
    int cyc;
    clear_stats();
    issue_cmd(1'b1, 32'h10, 4, 4'hF);
    wait_done(100, "write_done", cyc);
    @(negedge clk); #1;
    n_cmp++; if (exp_acc.size() != 0) begin n_bad++; $display("FAIL write_beats_left: got %0d required 0", exp_acc.size()); end
    n_cmp++; if (acc_cnt != 4) begin n_bad++; $display("FAIL write_accepts: got %0d required 4", acc_cnt); end
    n_cmp++; if (wr_ready_cnt != 4) begin n_bad++; $display("FAIL wr_ready_pulses: got %0d required 4", wr_ready_cnt); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL write_done_count: got %0d required 1", done_cnt); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b required 0", err); end
  endtask

  task automatic test_read_stall();
    int cyc;
    clear_stats();
    stall_left = 2;
    issue_cmd(1'b0, 32'h0, 3, 4'hF);
    wait_done(100, "read_stall_done", cyc);
    @(negedge clk); #1;
    n_cmp++; if (rd_valid_cnt != 3) begin n_bad++; $display("FAIL read_stall_rd_valid: got %0d required 3", rd_valid_cnt); end
    n_cmp++; if (exp_rd.size() != 0) begin n_bad++; $display("FAIL read_stall_left: got %0d required 0", exp_rd.size()); end
  endtask

  task automatic test_max_outstanding();
    int cyc;
    clear_stats();
    ack_hold = 10;
    issue_cmd(1'b0, 32'h40, 8, 4'hF);
    wait_done(200, "max_out_done", cyc);
    @(negedge clk); #1;
    n_cmp++; if (max_pend != MAX_OUT) begin n_bad++; $display("FAIL max_outstanding: got %0d required %0d", max_pend, MAX_OUT); end
    n_cmp++; if (stb_viol != 0) begin n_bad++; $display("FAIL stb_when_full: got %0d cycles required 0", stb_viol); end
    n_cmp++; if (rd_valid_cnt != 8) begin n_bad++; $display("FAIL max_out_rd_valid: got %0d required 8", rd_valid_cnt); end
  endtask

  task automatic test_err_abort();
    int cyc;
    clear_stats();
    err_mode = 1;
    issue_cmd(1'b1, 32'h100, 2, 4'h3);
    wait_done(100, "err_done", cyc);
    n_cmp++; if (o_wb_cyc !== 1'b0 || err !== 1'b1) begin
      n_bad++; $display("FAIL err_abort: cyc=%b err=%b required 0/1", o_wb_cyc, err);
    end
    @(negedge clk);
    flush();
    issue_cmd(1'b1, 32'h20, 1, 4'hF);
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b required 0", err); end
    wait_done(100, "after_err_done", cyc);
    @(negedge clk); #1;
    n_cmp++; if (exp_acc.size() != 0 || err !== 1'b0) begin
      n_bad++; $display("FAIL after_err_cmd: beats_left=%0d err=%b required 0/0", exp_acc.size(), err);
    end
  endtask

  task automatic test_timeout_and_zero();
    int cyc;
    clear_stats();
    never_ack = 1;
    issue_cmd(1'b0, 32'h0, 1, 4'hF);
    wait_done(TIMEOUT + 50, "timeout_done", cyc);
    n_cmp++; if (cyc < TIMEOUT || cyc > TIMEOUT + 6 || err !== 1'b1) begin
      n_bad++; $display("FAIL timeout: done after %0d cycles err=%b required %0d..%0d cycles err=1", cyc, err, TIMEOUT, TIMEOUT + 6);
    end
    never_ack = 0;
    @(negedge clk);
    flush();
    clear_stats();
    issue_cmd(1'b0, 32'h30, 0, 4'hF);
    n_cmp++; if (done !== 1'b1 || o_wb_cyc !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL zero_len: done=%b cyc=%b err=%b required 1/0/0", done, o_wb_cyc, err);
    end
    @(negedge clk); #1;
    n_cmp++; if (done !== 1'b0 || acc_cnt != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL zero_len_after: done=%b accepts=%0d busy=%b required 0/0/0", done, acc_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    int cyc;
    bit hit;
    clear_stats();
    hit = 0;
    issue_cmd(1'b1, 32'h200, 6, 4'hF);
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk); #1;
      if (acc_cnt >= 3) hit = 1;
    end
    if (!hit) begin n_cmp++; n_bad++; $display("FAIL mid_accepts: got %0d required 3", acc_cnt); end
    #2;
    reset = 1;
    #1;
    n_cmp++;
    if ({o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel, wr_ready, rd_data,
         rd_valid, busy, done, err, cmd_ready} !== '0) begin
      n_bad++; $display("FAIL mid_reset_outputs: cyc=%b stb=%b addr=%h busy=%b required all 0",
                        o_wb_cyc, o_wb_stb, o_wb_addr, busy);
    end
    repeat (2) @(negedge clk);
    flush();
    reset = 0;
    issue_cmd(1'b1, 32'h86, 2, 4'h3);
    wait_done(100, "post_reset_done", cyc);
    @(negedge clk); #1;
    n_cmp++; if (exp_acc.size() != 0 || err !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_cmd: beats_left=%0d err=%b required 0/0", exp_acc.size(), err);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hD000_0000 + 32'(i * 32'h0101);
    test_reset();
    test_write_burst();
    test_read_stall();
    test_max_outstanding();
    test_err_abort();
    test_timeout_and_zero();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
